seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_pkg.sv | 55 +++++
 rtl/seg_scan_ctrl_bin2bcd_seq.sv | 86 ++++++++
 rtl/seg_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller:
// active-low glyphs (seg[0]=a .. seg[6]=g), mode encodings, converter states.
package seg_scan_ctrl_pkg;

  localparam logic MODE_HEX = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  typedef enum logic [1:0] {
    CONV_IDLE = 2'd0,
    CONV_RUN  = 2'd1,
    CONV_DONE = 2'd2
  } conv_state_e;

  function automatic logic [6:0] hex_glyph(input logic [3:0] d);
    case (d)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per cycle, DATA_W steps total.
// The first step is folded into the start cycle so done pulses after DATA_W shifts.
module bin2bcd_seq
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DATA_W-1:0]         bin,
  output logic                      done,
  output logic [4*NUM_DIGITS-1:0]   bcd,
  output logic                      overflow
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(DATA_W - 1);

  conv_state_e      state;
  logic [DATA_W-1:0] sr;
  logic [BCD_W-1:0]  acc;
  logic [BCD_W-1:0]  adj;
  logic [BCD_W-1:0]  acc_shift;
  logic              carry;
  logic              ovf;
  logic [CNT_W-1:0]  cnt;

  // Add-3 correction then shift; a bit leaving the top digit means >= 10^NUM_DIGITS.
  always_comb begin
    adj = acc;
    for (int d = 0; d < int'(NUM_DIGITS); d++) begin
      if (acc[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
    {carry, acc_shift} = {adj, sr[DATA_W-1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CONV_IDLE;
      sr       <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        CONV_IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc   <= BCD_W'(bin[DATA_W-1]);
            sr    <= bin << 1;
            ovf   <= 1'b0;
            cnt   <= CNT_W'(1);
            state <= CONV_RUN;
          end
        end
        CONV_RUN: begin
          acc <= acc_shift;
          sr  <= sr << 1;
          ovf <= ovf | carry;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_SHIFT) begin
            state    <= CONV_DONE;
            done     <= 1'b1;
            bcd      <= acc_shift;
            overflow <= ovf | carry;
          end
        end
        CONV_DONE: begin
          done  <= 1'b0;
          state <= CONV_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= CONV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment display controller: refresh prescaler, digit scan,
// hex or decimal display register, leading-zero blanking and overflow dashes.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_DIGITS  = 4,
  parameter  int unsigned REFRESH_DIV = 100000,
  localparam int unsigned DATA_W      = 4 * NUM_DIGITS,
  localparam int unsigned IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  input  logic                  mode,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [IDX_W-1:0]      changer,
  output logic                  clk_out,
  output logic                  busy
);

  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] LAST_CNT = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]      pre_cnt;
  logic [PRE_W-1:0]      pre_nxt;
  logic                  clk_out_nxt;
  logic [IDX_W-1:0]      chg_nxt;
  logic [DATA_W-1:0]     disp;
  logic [DATA_W-1:0]     disp_nxt;
  logic                  disp_ovf;
  logic                  ovf_nxt;
  logic                  busy_nxt;
  logic                  load_ok;
  logic                  conv_start;
  logic                  conv_done;
  logic [DATA_W-1:0]     conv_bcd;
  logic                  conv_ovf;
  logic                  zero_run;
  logic                  sel_blank;
  logic [3:0]            nib;
  logic [3:0]            sel_nib;
  logic [6:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk      (clk),
    .reset    (reset),
    .start    (conv_start),
    .bin      (value),
    .done     (conv_done),
    .bcd      (conv_bcd),
    .overflow (conv_ovf)
  );

  // Next-state for prescaler, scan index and display register.
  always_comb begin
    pre_nxt     = (pre_cnt == LAST_CNT) ? '0 : pre_cnt + PRE_W'(1);
    clk_out_nxt = (pre_nxt == LAST_CNT);
    chg_nxt     = changer;
    if (clk_out) chg_nxt = (changer == LAST_IDX) ? '0 : changer + IDX_W'(1);
    an_nxt      = ~(NUM_DIGITS'(1) << chg_nxt);

    load_ok    = load && !busy;
    conv_start = load_ok && (mode == MODE_DEC);
    disp_nxt   = disp;
    ovf_nxt    = disp_ovf;
    busy_nxt   = busy;
    if (load_ok && (mode == MODE_HEX)) begin
      disp_nxt = value;
      ovf_nxt  = 1'b0;
    end
    if (conv_start) busy_nxt = 1'b1;
    if (conv_done) begin
      disp_nxt = conv_bcd;
      ovf_nxt  = conv_ovf;
      busy_nxt = 1'b0;
    end
  end

  // Digit mux; zero_run stays set while every digit from the top down is zero.
  always_comb begin
    zero_run  = blank_lz && !ovf_nxt;
    sel_blank = 1'b0;
    sel_nib   = 4'd0;
    nib       = 4'd0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      nib = disp_nxt[4*i +: 4];
      if (nib != 4'd0) zero_run = 1'b0;
      if (IDX_W'(i) == chg_nxt) begin
        sel_nib   = nib;
        sel_blank = zero_run && (i != 0);
      end
    end
    if (ovf_nxt)        seg_nxt = SEG_DASH;
    else if (sel_blank) seg_nxt = SEG_BLANK;
    else                seg_nxt = hex_glyph(sel_nib);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt  <= '0;
      clk_out  <= 1'b0;
      changer  <= '0;
      disp     <= '0;
      disp_ovf <= 1'b0;
      busy     <= 1'b0;
      an       <= ~NUM_DIGITS'(1);
      seg      <= hex_glyph(4'd0);
    end else begin
      pre_cnt  <= pre_nxt;
      clk_out  <= clk_out_nxt;
      changer  <= chg_nxt;
      disp     <= disp_nxt;
      disp_ovf <= ovf_nxt;
      busy     <= busy_nxt;
      an       <= an_nxt;
      seg      <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (4 digits, refresh every 4 clocks).
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic        mode;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  changer;
  logic        clk_out;
  logic        busy;

  int checks;
  int errors;

  typedef struct {
    int         idx;
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t sb[$];

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .mode     (mode),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an),
    .changer  (changer),
    .clk_out  (clk_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ref_glyph(input int d);
    case (d)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Expected per-digit (an, seg) for a value as the display should show it.
  task automatic push_expected(input logic [15:0] v, input logic dec, input logic blank);
    int   digit[4];
    int   x;
    int   top;
    bit   ovf;
    exp_t e;
    ovf = 1'b0;
    x   = int'(v);
    if (dec) begin
      if (x > 9999) ovf = 1'b1;
      for (int i = 0; i < 4; i++) begin
        digit[i] = x % 10;
        x = x / 10;
      end
    end else begin
      for (int i = 0; i < 4; i++) digit[i] = (x >> (4 * i)) & 15;
    end
    top = 0;
    for (int i = 0; i < 4; i++) if (digit[i] != 0) top = i;
    for (int i = 0; i < 4; i++) begin
      e.idx = i;
      e.an  = ~(4'(1 << i));
      if (ovf)                   e.seg = 7'b0111111;
      else if (blank && i > top) e.seg = 7'b1111111;
      else                       e.seg = ref_glyph(digit[i]);
      sb.push_back(e);
    end
  endtask

  // Caller is at a negedge; load is held for exactly one rising edge.
  task automatic do_load(input logic [15:0] v, input logic m);
    value = v;
    mode  = m;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%b required 0", name, busy);
    end
  endtask

  // Align to the start of digit 0, then pop one expected entry per slot.
  task automatic check_scan(input string name);
    int   guard;
    exp_t e;
    guard = 0;
    while (!(clk_out === 1'b1 && changer === 2'd3) && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) begin
      checks++;
      errors++;
      $display("FAIL %s_align_timeout: changer=%0d clk_out=%b required 3/1", name, changer, clk_out);
      sb.delete();
      return;
    end
    for (int s = 0; s < ND; s++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s_sb_empty: slot %0d has no expected entry", name, s);
      end else begin
        e = sb.pop_front();
        if (changer !== 2'(e.idx)) begin
          errors++;
          $display("FAIL %s_changer: slot %0d got %0d required %0d", name, s, changer, e.idx);
        end
        checks++;
        if (an !== e.an) begin
          errors++;
          $display("FAIL %s_an: digit %0d got %b required %b", name, e.idx, an, e.an);
        end
        checks++;
        if (seg !== e.seg) begin
          errors++;
          $display("FAIL %s_seg: digit %0d got %b required %b", name, e.idx, seg, e.seg);
        end
      end
      for (int k = 1; k < RD; k++) begin
        @(negedge clk);
        checks++;
        if (clk_out !== 1'(k == RD - 1)) begin
          errors++;
          $display("FAIL %s_clk_out: slot %0d cycle %0d got %b required %b", name, s, k, clk_out, (k == RD - 1));
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_leftover: %0d entries left required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    load     = 1'b0;
    value    = '0;
    mode     = 1'b0;
    blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (an !== 4'b1110) begin errors++; $display("FAIL reset_an: got %b required 1110", an); end
    checks++;
    if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg: got %b required 1000000", seg); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++;
    if (clk_out !== 1'b0) begin errors++; $display("FAIL reset_clk_out: got %b required 0", clk_out); end
    checks++;
    if (changer !== 2'd0) begin errors++; $display("FAIL reset_changer: got %0d required 0", changer); end
    reset = 1'b0;
    push_expected(16'h0000, 1'b0, 1'b0);
    check_scan("reset_scan");
  endtask

  task automatic test_hex();
    blank_lz = 1'b0;
    push_expected(16'h1A3F, 1'b0, 1'b0);
    do_load(16'h1A3F, 1'b0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL hex_busy: got %b required 0", busy); end
    check_scan("hex");
  endtask

  task automatic test_decimal();
    int n;
    push_expected(16'd1234, 1'b1, 1'b0);
    do_load(16'd1234, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == 3) begin
        value = 16'h0042;
        mode  = 1'b0;
        load  = 1'b1;
      end else begin
        load  = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    checks++;
    if (n !== 16) begin errors++; $display("FAIL dec_busy_cycles: got %0d required 16", n); end
    check_scan("dec_1234");
  endtask

  task automatic test_dec_max();
    push_expected(16'd9999, 1'b1, 1'b0);
    do_load(16'd9999, 1'b1);
    wait_idle("dec_9999");
    check_scan("dec_9999");
  endtask

  task automatic test_overflow();
    push_expected(16'd10000, 1'b1, 1'b0);
    do_load(16'd10000, 1'b1);
    wait_idle("ovf");
    check_scan("ovf");
    blank_lz = 1'b1;
    push_expected(16'd10000, 1'b1, 1'b1);
    check_scan("ovf_blank");
  endtask

  task automatic test_blank();
    blank_lz = 1'b1;
    push_expected(16'h0005, 1'b0, 1'b1);
    do_load(16'h0005, 1'b0);
    check_scan("blank_lz");
    blank_lz = 1'b0;
  endtask

  task automatic test_reset_mid_conv();
    int busy_seen;
    blank_lz = 1'b0;
    do_load(16'h8888, 1'b0);
    do_load(16'd1234, 1'b1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    load  = 1'b1;
    value = 16'h7777;
    mode  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    load  = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
    checks++;
    if (an !== 4'b1110) begin errors++; $display("FAIL midrst_an: got %b required 1110", an); end
    checks++;
    if (seg !== 7'b1000000) begin errors++; $display("FAIL midrst_seg: got %b required 1000000", seg); end
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin errors++; $display("FAIL midrst_busy_later: busy cycles %0d required 0", busy_seen); end
    push_expected(16'h0000, 1'b0, 1'b0);
    check_scan("midrst_scan");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_hex();
    test_decimal();
    test_dec_max();
    test_overflow();
    test_blank();
    test_reset_mid_conv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
